rvfi_retire_buffer: RTL and testbench
=====================================

# rvfi_retire_buffer

Multi-lane RVFI retirement buffer between the core's retire stage and the riscv-formal / trace interface. It accepts up to NRET_IN retired-instruction records per cycle and compacts them in lane order into a DEPTH-entry FIFO. Each record gets a monotonically increasing 64-bit rvfi_order, and the buffer replays records one per cycle on a single-lane RVFI port with consumer backpressure. This lets a wider-issue datapath drive the existing single-retire RVFI checks unchanged.

## Interface
- NRET_IN, 2: retire lanes from core (1..4)
- DEPTH, 8: FIFO entries; power of two, ≥ NRET_IN
- XLEN, 32: data width
- ILEN, 32: instruction width
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clock)
- in_valid  in  NRET_IN  per-lane record valid; lane 0 oldest
- in_insn  in  NRET_IN*ILEN  instruction word per lane
- in_trap  in  NRET_IN  trap flag per lane
- in_pc_rdata, in_pc_wdata  in  NRET_IN*XLEN  PC before/after
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  NRET_IN*5  register indices
- in_rs1_rdata, in_rs2_rdata, in_rd_wdata  in  NRET_IN*XLEN  register data
- in_mem_addr, in_mem_rdata, in_mem_wdata  in  NRET_IN*XLEN  memory access
- in_mem_rmask, in_mem_wmask  in  NRET_IN*XLEN/8  byte masks
- in_ready  out  1  buffer can take a full NRET_IN-lane beat this cycle
- out_ready  in  1  consumer accepts the current rvfi record
- rvfi_valid  out  1  record at head valid
- rvfi_order  out  64  retirement sequence number
- rvfi_insn, rvfi_trap, rvfi_pc_*, rvfi_rs*_*, rvfi_rd_*, rvfi_mem_*  out  per RVFI single-lane widths  head record fields
- rvfi_halt, rvfi_intr  out  1  constant 0
- rvfi_mode  out  2  constant 2'b11 (M-mode)
- rvfi_ixl  out  2  constant 2'b01 (XLEN 32)
- fill_level  out  $clog2(DEPTH+1)  occupied entries
- dropped  out  1  sticky: a beat was offered while in_ready=0

## Operation
- Enqueue condition: |in_valid && in_ready.
  - Valid lanes are compacted in ascending lane order into consecutive slots from the write pointer.
  - Any valid subset is legal. For example, in_valid=4'b1010 writes lane 1 then lane 3.
- Order assignment:
  - Each enqueued record takes order_ctr + k, where k is its rank among valid lanes.
  - order_ctr advances by popcount(in_valid). It wraps at 2^64.
- RVFI legality fix-up at enqueue: if rd_addr==0, the stored rd_wdata is forced to 0.
- in_ready = (DEPTH − fill_level) ≥ NRET_IN. This is conservative: it is independent of how many lanes are valid.
- Drop: if |in_valid && !in_ready, nothing is written and dropped sets. dropped clears only on reset.
- Dequeue condition: rvfi_valid && out_ready. The read pointer then advances by 1.
- The FIFO is show-ahead. All rvfi_* data outputs reflect the head entry whenever rvfi_valid=1, and hold their last values when rvfi_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level tracks occupancy.
- Simultaneous enqueue and dequeue: fill_level' = fill_level + popcount − 1. A full beat is accepted only if the pre-dequeue free count is ≥ NRET_IN.
- Reset (reset=0 at an edge):
  - Pointers, fill_level, order_ctr and dropped go to 0; rvfi_valid=0.
  - Buffered records are discarded and any in-flight beat is ignored.
  - A reset mid-stream means the next accepted record gets order 0.

## Timing
- Enqueue at edge N → rvfi_valid=1 after edge N (same-cycle visibility is not allowed), provided the FIFO was empty.
- Throughput: 1 record/cycle out. Input sustains NRET_IN/cycle only while out_ready keeps occupancy low.
- in_ready and rvfi_valid are pure functions of registered state, with no combinational path from in_valid or out_ready.
- Reset values: rvfi_valid=0, in_ready=1, fill_level=0, dropped=0, rvfi_order=0, all data outputs 0.

## Test plan
- Single-lane beats: NRET_IN=2, in_valid=2'b01 on 3 consecutive cycles with out_ready=1 → rvfi_valid from cycle 2, orders 0, 1, 2 in sequence, fill_level ≤ 1.
- Compaction: in_valid=2'b10 (insn 0x00000013), then 2'b11 (insn A on lane 0, B on lane 1) → output order 0x13(0), A(1), B(2).
- Fill and backpressure: DEPTH=8, out_ready=0, four 2'b11 beats → fill_level=8, in_ready=0. A fifth beat sets dropped=1 and fill_level stays 8. Then out_ready=1 drains exactly 8 records with orders 0..7.
- Simultaneous: fill_level=6, out_ready=1, a 2'b11 beat → accepted, fill_level=7 next cycle.
- x0 fix-up: lane with rd_addr=0, rd_wdata=0xDEADBEEF → rvfi_rd_wdata=0.
- Reset mid-operation: reset=0 for one edge while fill_level=5 and dropped=1 → next cycle rvfi_valid=0, fill_level=0, dropped=0; next accepted record has rvfi_order=0.

Source files
------------

// File: rtl/rvfi_retire_buffer_if.sv
// rvfi_retire_buffer_if: multi-lane retire input bundle and single-lane RVFI output bundle
interface rvfi_retire_buffer_if #(
  parameter int NRET_IN = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic [NRET_IN-1:0] in_valid;
  logic [NRET_IN-1:0] in_trap;
  logic [NRET_IN*ILEN-1:0] in_insn;
  logic [NRET_IN*XLEN-1:0] in_pc_rdata, in_pc_wdata;
  logic [NRET_IN*5-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [NRET_IN*XLEN-1:0] in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
  logic [NRET_IN*XLEN-1:0] in_mem_addr, in_mem_rdata, in_mem_wdata;
  logic [NRET_IN*XLEN/8-1:0] in_mem_rmask, in_mem_wmask;
  logic in_ready;
  logic out_ready;
  logic rvfi_valid;
  logic [63:0] rvfi_order;
  logic [ILEN-1:0] rvfi_insn;
  logic rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0] rvfi_mode, rvfi_ixl;
  logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [XLEN-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic [$clog2(DEPTH+1)-1:0] fill_level;
  logic dropped;
  modport master (
    output in_valid, in_trap, in_insn, in_pc_rdata, in_pc_wdata,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
           in_mem_addr, in_mem_rdata, in_mem_wdata, in_mem_rmask, in_mem_wmask, out_ready,
    input  in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_mode, rvfi_ixl, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
           rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
           rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, fill_level, dropped
  );
  modport slave (
    input  in_valid, in_trap, in_insn, in_pc_rdata, in_pc_wdata,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
           in_mem_addr, in_mem_rdata, in_mem_wdata, in_mem_rmask, in_mem_wmask, out_ready,
    output in_ready, rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_mode, rvfi_ixl, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
           rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr,
           rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask, fill_level, dropped
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// rvfi_retire_buffer: compacts multi-lane retirements into a FIFO and replays them one per cycle on RVFI
module rvfi_retire_buffer #(
  parameter int NRET_IN = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input logic clock,
  input logic reset,
  rvfi_retire_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [63:0] order;
    logic [ILEN-1:0] insn;
    logic trap;
    logic [XLEN-1:0] pc_rdata, pc_wdata;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_rdata, rs2_rdata, rd_wdata;
    logic [XLEN-1:0] mem_addr, mem_rdata, mem_wdata;
    logic [XLEN/8-1:0] mem_rmask, mem_wmask;
  } rec_t;
  rec_t mem [DEPTH];
  rec_t rec [NRET_IN];
  rec_t last, cur;
  logic [PW-1:0] slot [NRET_IN];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill, cnt;
  logic [63:0] order_ctr;
  logic dropped_q, enq, deq;
  assign bus.in_ready = (FW'(DEPTH) - fill) >= FW'(NRET_IN);
  assign bus.rvfi_valid = fill != '0;
  assign enq = |bus.in_valid && bus.in_ready;
  assign deq = bus.rvfi_valid && bus.out_ready;
  // running rank among valid lanes gives both the FIFO slot and the order offset
  always_comb begin
    cnt = '0;
    for (int l = 0; l < NRET_IN; l++) begin
      slot[l] = wr_ptr + cnt[PW-1:0];
      rec[l].order = order_ctr + 64'(cnt);
      rec[l].insn = bus.in_insn[l*ILEN +: ILEN];
      rec[l].trap = bus.in_trap[l];
      rec[l].pc_rdata = bus.in_pc_rdata[l*XLEN +: XLEN];
      rec[l].pc_wdata = bus.in_pc_wdata[l*XLEN +: XLEN];
      rec[l].rs1_addr = bus.in_rs1_addr[l*5 +: 5];
      rec[l].rs2_addr = bus.in_rs2_addr[l*5 +: 5];
      rec[l].rd_addr = bus.in_rd_addr[l*5 +: 5];
      rec[l].rs1_rdata = bus.in_rs1_rdata[l*XLEN +: XLEN];
      rec[l].rs2_rdata = bus.in_rs2_rdata[l*XLEN +: XLEN];
      rec[l].rd_wdata = bus.in_rd_addr[l*5 +: 5] == 5'd0 ? '0 : bus.in_rd_wdata[l*XLEN +: XLEN];
      rec[l].mem_addr = bus.in_mem_addr[l*XLEN +: XLEN];
      rec[l].mem_rdata = bus.in_mem_rdata[l*XLEN +: XLEN];
      rec[l].mem_wdata = bus.in_mem_wdata[l*XLEN +: XLEN];
      rec[l].mem_rmask = bus.in_mem_rmask[l*XLEN/8 +: XLEN/8];
      rec[l].mem_wmask = bus.in_mem_wmask[l*XLEN/8 +: XLEN/8];
      cnt = cnt + FW'(bus.in_valid[l]);
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      order_ctr <= '0;
      dropped_q <= 1'b0;
      last <= '0;
    end else begin
      if (enq) begin
        for (int l = 0; l < NRET_IN; l++)
          if (bus.in_valid[l]) mem[slot[l]] <= rec[l];
        wr_ptr <= wr_ptr + cnt[PW-1:0];
        order_ctr <= order_ctr + 64'(cnt);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
        last <= mem[rd_ptr];
      end
      if (|bus.in_valid && !bus.in_ready) dropped_q <= 1'b1;
      fill <= fill + (enq ? cnt : '0) - FW'(deq);
    end
  end
  // when empty, the last dequeued record is held on the outputs
  assign cur = bus.rvfi_valid ? mem[rd_ptr] : last;
  assign bus.rvfi_order = cur.order;
  assign bus.rvfi_insn = cur.insn;
  assign bus.rvfi_trap = cur.trap;
  assign bus.rvfi_pc_rdata = cur.pc_rdata;
  assign bus.rvfi_pc_wdata = cur.pc_wdata;
  assign bus.rvfi_rs1_addr = cur.rs1_addr;
  assign bus.rvfi_rs2_addr = cur.rs2_addr;
  assign bus.rvfi_rd_addr = cur.rd_addr;
  assign bus.rvfi_rs1_rdata = cur.rs1_rdata;
  assign bus.rvfi_rs2_rdata = cur.rs2_rdata;
  assign bus.rvfi_rd_wdata = cur.rd_wdata;
  assign bus.rvfi_mem_addr = cur.mem_addr;
  assign bus.rvfi_mem_rdata = cur.mem_rdata;
  assign bus.rvfi_mem_wdata = cur.mem_wdata;
  assign bus.rvfi_mem_rmask = cur.mem_rmask;
  assign bus.rvfi_mem_wmask = cur.mem_wmask;
  assign bus.rvfi_halt = 1'b0;
  assign bus.rvfi_intr = 1'b0;
  assign bus.rvfi_mode = 2'b11;
  assign bus.rvfi_ixl = 2'b01;
  assign bus.fill_level = fill;
  assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// tb_rvfi_retire_buffer: scoreboard bench for the multi-lane RVFI retire buffer
module tb_rvfi_retire_buffer;
  localparam int NRET = 2, DEPTH = 8, XLEN = 32, ILEN = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rvfi_retire_buffer_if #(.NRET_IN(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) bus();
  rvfi_retire_buffer #(.NRET_IN(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [63:0] order;
    logic [31:0] insn, pc_rdata, rd_wdata, mem_addr;
    logic [4:0] rd_addr;
    logic trap;
  } exp_t;
  exp_t q[$];
  exp_t m_e, p_e;
  int total = 0, passed = 0, m_fill = 0, m_n = 0, deq_cnt = 0;
  logic [63:0] m_order = '0;
  logic m_dropped = 1'b0, m_acc, m_dq;
  // reference model: predicts acceptance and pushes expected records at each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_fill = 0;
      m_order = '0;
      m_dropped = 1'b0;
      q.delete();
    end else begin
      m_acc = |bus.in_valid && (DEPTH - m_fill) >= NRET;
      m_dq = m_fill != 0 && bus.out_ready;
      m_n = 0;
      if (|bus.in_valid && !m_acc) m_dropped = 1'b1;
      if (m_acc)
        for (int l = 0; l < NRET; l++)
          if (bus.in_valid[l]) begin
            m_e.order = m_order;
            m_e.insn = bus.in_insn[l*32 +: 32];
            m_e.pc_rdata = bus.in_pc_rdata[l*32 +: 32];
            m_e.rd_addr = bus.in_rd_addr[l*5 +: 5];
            m_e.rd_wdata = m_e.rd_addr == 5'd0 ? 32'd0 : bus.in_rd_wdata[l*32 +: 32];
            m_e.mem_addr = bus.in_mem_addr[l*32 +: 32];
            m_e.trap = bus.in_trap[l];
            q.push_back(m_e);
            m_order = m_order + 64'd1;
            m_n++;
          end
      m_fill = m_fill + m_n - (m_dq ? 1 : 0);
    end
  end
  // monitor: status checks every cycle, scoreboard pop on each handshake
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (bus.rvfi_valid !== (m_fill != 0)) $display("FAIL mon_valid: got %b want %b", bus.rvfi_valid, m_fill != 0);
      else passed++;
      total++;
      if (bus.fill_level !== 4'(m_fill)) $display("FAIL mon_fill: got %0d want %0d", bus.fill_level, m_fill);
      else passed++;
      total++;
      if (bus.in_ready !== ((DEPTH - m_fill) >= NRET)) $display("FAIL mon_in_ready: got %b want %b", bus.in_ready, (DEPTH - m_fill) >= NRET);
      else passed++;
      total++;
      if (bus.dropped !== m_dropped) $display("FAIL mon_dropped: got %b want %b", bus.dropped, m_dropped);
      else passed++;
      if (bus.rvfi_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) $display("FAIL mon_underflow: got record order %0d want none", bus.rvfi_order);
        else begin
          p_e = q.pop_front();
          deq_cnt++;
          if ({bus.rvfi_order, bus.rvfi_insn, bus.rvfi_pc_rdata, bus.rvfi_rd_addr, bus.rvfi_rd_wdata, bus.rvfi_mem_addr, bus.rvfi_trap}
              !== {p_e.order, p_e.insn, p_e.pc_rdata, p_e.rd_addr, p_e.rd_wdata, p_e.mem_addr, p_e.trap})
            $display("FAIL mon_record: got order %0d insn %h rd %0d wdata %h want order %0d insn %h rd %0d wdata %h",
                     bus.rvfi_order, bus.rvfi_insn, bus.rvfi_rd_addr, bus.rvfi_rd_wdata, p_e.order, p_e.insn, p_e.rd_addr, p_e.rd_wdata);
          else passed++;
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_lane(input int l, input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] wd);
    bus.in_insn[l*32 +: 32] = insn;
    bus.in_trap[l] = insn[2];
    bus.in_pc_rdata[l*32 +: 32] = insn ^ 32'h8000_0000;
    bus.in_pc_wdata[l*32 +: 32] = insn + 32'd4;
    bus.in_rs1_addr[l*5 +: 5] = insn[19:15];
    bus.in_rs2_addr[l*5 +: 5] = insn[24:20];
    bus.in_rd_addr[l*5 +: 5] = rd;
    bus.in_rs1_rdata[l*32 +: 32] = ~insn;
    bus.in_rs2_rdata[l*32 +: 32] = insn << 1;
    bus.in_rd_wdata[l*32 +: 32] = wd;
    bus.in_mem_addr[l*32 +: 32] = insn ^ 32'h0000_ffff;
    bus.in_mem_rdata[l*32 +: 32] = insn >> 1;
    bus.in_mem_wdata[l*32 +: 32] = insn + 32'd100;
    bus.in_mem_rmask[l*4 +: 4] = insn[3:0];
    bus.in_mem_wmask[l*4 +: 4] = insn[7:4];
  endtask
  task automatic beat(input logic [1:0] v);
    bus.in_valid = v;
    tick();
    bus.in_valid = '0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.in_valid = 2'b11;
    tick();
    rst_n = 1'b1;
    bus.in_valid = '0;
  endtask
  task automatic drain;
    int n = 0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (q.size() != 0) $display("FAIL drain_timeout: got %0d records left want 0", q.size());
    else passed++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 2'b11;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    bus.in_valid = '0;
    total++;
    if ({bus.rvfi_valid, bus.in_ready, bus.fill_level, bus.dropped} !== {1'b0, 1'b1, 4'd0, 1'b0})
      $display("FAIL reset_status: got valid %b ready %b fill %0d dropped %b want 0 1 0 0", bus.rvfi_valid, bus.in_ready, bus.fill_level, bus.dropped);
    else passed++;
    total++;
    if ({bus.rvfi_order, bus.rvfi_insn, bus.rvfi_rd_wdata, bus.rvfi_pc_rdata} !== 160'd0)
      $display("FAIL reset_data: got order %0d insn %h wdata %h want all 0", bus.rvfi_order, bus.rvfi_insn, bus.rvfi_rd_wdata);
    else passed++;
    total++;
    if ({bus.rvfi_halt, bus.rvfi_intr, bus.rvfi_mode, bus.rvfi_ixl} !== 6'b00_11_01)
      $display("FAIL reset_consts: got %b want 001101", {bus.rvfi_halt, bus.rvfi_intr, bus.rvfi_mode, bus.rvfi_ixl});
    else passed++;
  endtask
  task automatic test_single_lane;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 32'h0010_0093 + 32'(i << 20), 5'd1, 32'(i + 10));
      beat(2'b01);
      total++;
      if (bus.rvfi_valid !== 1'b1 || bus.rvfi_order !== 64'(i) || bus.fill_level > 4'd1)
        $display("FAIL single_lane_%0d: got valid %b order %0d fill %0d want 1 %0d <=1", i, bus.rvfi_valid, bus.rvfi_order, bus.fill_level, i);
      else passed++;
    end
    drain();
  endtask
  task automatic test_compaction;
    logic [31:0] ex [3];
    ex[0] = 32'h0000_0013;
    ex[1] = 32'h00a0_0513;
    ex[2] = 32'h00b0_0593;
    do_reset();
    bus.out_ready = 1'b0;
    set_lane(0, 32'hffff_ffff, 5'd3, 32'h1);
    set_lane(1, ex[0], 5'd0, 32'h0);
    beat(2'b10);
    set_lane(0, ex[1], 5'd10, 32'ha);
    set_lane(1, ex[2], 5'd11, 32'hb);
    beat(2'b11);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.rvfi_insn !== ex[i] || bus.rvfi_order !== 64'(i))
        $display("FAIL compaction_%0d: got insn %h order %0d want %h %0d", i, bus.rvfi_insn, bus.rvfi_order, ex[i], i);
      else passed++;
      tick();
    end
    drain();
  endtask
  task automatic test_fill_backpressure;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 32'h1000 + 32'(2 * i), 5'd1, 32'h55);
      set_lane(1, 32'h1001 + 32'(2 * i), 5'd2, 32'h66);
      beat(2'b11);
    end
    total++;
    if ({bus.fill_level, bus.in_ready, bus.dropped} !== {4'd8, 1'b0, 1'b0})
      $display("FAIL full_state: got fill %0d ready %b dropped %b want 8 0 0", bus.fill_level, bus.in_ready, bus.dropped);
    else passed++;
    set_lane(0, 32'h2000, 5'd1, 32'h77);
    beat(2'b11);
    total++;
    if ({bus.fill_level, bus.dropped} !== {4'd8, 1'b1})
      $display("FAIL drop_state: got fill %0d dropped %b want 8 1", bus.fill_level, bus.dropped);
    else passed++;
    deq_cnt = 0;
    drain();
    total++;
    if (deq_cnt != 8 || bus.rvfi_valid !== 1'b0) $display("FAIL drain_count: got %0d valid %b want 8 0", deq_cnt, bus.rvfi_valid);
    else passed++;
    total++;
    if (bus.rvfi_order !== 64'd7 || bus.rvfi_insn !== 32'h1007)
      $display("FAIL hold_last: got order %0d insn %h want 7 00001007", bus.rvfi_order, bus.rvfi_insn);
    else passed++;
  endtask
  task automatic test_simultaneous;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 32'h3000 + 32'(2 * i), 5'd4, 32'h1);
      set_lane(1, 32'h3001 + 32'(2 * i), 5'd5, 32'h2);
      beat(2'b11);
    end
    total++;
    if (bus.fill_level !== 4'd6) $display("FAIL simul_pre: got fill %0d want 6", bus.fill_level);
    else passed++;
    bus.out_ready = 1'b1;
    set_lane(0, 32'h3100, 5'd4, 32'h3);
    set_lane(1, 32'h3101, 5'd5, 32'h4);
    beat(2'b11);
    total++;
    if (bus.fill_level !== 4'd7) $display("FAIL simul_post: got fill %0d want 7", bus.fill_level);
    else passed++;
    drain();
  endtask
  task automatic test_x0_fixup;
    do_reset();
    bus.out_ready = 1'b0;
    set_lane(0, 32'hdead_0013, 5'd0, 32'hdead_beef);
    set_lane(1, 32'h0050_0293, 5'd5, 32'h1234_5678);
    beat(2'b11);
    total++;
    if (bus.rvfi_valid !== 1'b1 || bus.rvfi_rd_addr !== 5'd0 || bus.rvfi_rd_wdata !== 32'd0)
      $display("FAIL x0_fixup: got valid %b rd %0d wdata %h want 1 0 00000000", bus.rvfi_valid, bus.rvfi_rd_addr, bus.rvfi_rd_wdata);
    else passed++;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.rvfi_rd_wdata !== 32'h1234_5678) $display("FAIL x0_other_lane: got %h want 12345678", bus.rvfi_rd_wdata);
    else passed++;
    drain();
  endtask
  task automatic test_reset_mid;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lane(0, 32'h4000 + 32'(2 * i), 5'd6, 32'h9);
      set_lane(1, 32'h4001 + 32'(2 * i), 5'd7, 32'h8);
      beat(2'b11);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({bus.fill_level, bus.dropped} !== {4'd5, 1'b1}) $display("FAIL mid_pre: got fill %0d dropped %b want 5 1", bus.fill_level, bus.dropped);
    else passed++;
    bus.out_ready = 1'b0;
    do_reset();
    total++;
    if ({bus.rvfi_valid, bus.fill_level, bus.dropped} !== {1'b0, 4'd0, 1'b0})
      $display("FAIL mid_reset: got valid %b fill %0d dropped %b want 0 0 0", bus.rvfi_valid, bus.fill_level, bus.dropped);
    else passed++;
    set_lane(0, 32'h4444_0013, 5'd8, 32'h7);
    beat(2'b01);
    total++;
    if (bus.rvfi_valid !== 1'b1 || bus.rvfi_order !== 64'd0 || bus.rvfi_insn !== 32'h4444_0013)
      $display("FAIL mid_restart: got valid %b order %0d insn %h want 1 0 44440013", bus.rvfi_valid, bus.rvfi_order, bus.rvfi_insn);
    else passed++;
    drain();
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int l = 0; l < NRET; l++) set_lane(l, $urandom, 5'($urandom_range(0, 3)), $urandom);
      bus.in_valid = 2'($urandom_range(0, 3));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
  endtask
  initial begin
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
    for (int l = 0; l < NRET; l++) set_lane(l, 32'd0, 5'd0, 32'd0);
    test_reset();
    test_single_lane();
    test_compaction();
    test_fill_backpressure();
    test_simultaneous();
    test_x0_fixup();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
